// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: accepts a word over valid/ready and shifts it out
// MSB-first on cs_n/sclk/mosi with a programmable sclk half-period.
module spi_master_tx #(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 8
) (
   input  logic              _i_clk,
   input  logic              _i_rst,
   input  logic [DATA_W-1:0] _i_data,
   input  logic              _i_valid,
   output logic [4:0]        __output
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t              state_q;
   logic [DIV_W-1:0]    div_q;
   logic [DIV_W-1:0]    div_d;
   logic                div_wrap_d;
   logic [BIT_W-1:0]    bit_q;
   logic [DATA_W-1:0]   sh_q;
   logic [DATA_W-1:0]   sh_d;
   logic                done_q;
   logic                ready_q;
   logic                cs_n_q;
   logic                sclk_q;
   logic                mosi_q;

   // Divider wrap detection and the shift register's next value.
   always_comb begin
      div_wrap_d = (div_q == DIV_W'(CLK_DIV - 1));
      if (div_wrap_d) begin
         div_d = '0;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
      sh_d = sh_q << 1;
   end

   // Frame sequencer; every output pin comes straight from a register here.
   always_ff @(posedge _i_clk or negedge _i_rst) begin
      if (!_i_rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               div_q <= '0;
               bit_q <= '0;
               if (_i_valid && ready_q) begin
                  sh_q    <= _i_data;
                  mosi_q  <= _i_data[DATA_W-1];
                  cs_n_q  <= 1'b0;
                  ready_q <= 1'b0;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               div_q <= div_d;
               if (div_wrap_d) begin
                  sclk_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               div_q <= div_d;
               if (div_wrap_d) begin
                  if (sclk_q) begin
                     sclk_q <= 1'b0;
                     // The last bit keeps mosi at the LSB through the cs hold half.
                     if (bit_q != BIT_W'(DATA_W - 1)) begin
                        sh_q   <= sh_d;
                        mosi_q <= sh_d[DATA_W-1];
                     end
                  end else if (bit_q == BIT_W'(DATA_W - 1)) begin
                     cs_n_q  <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= GAP;
                  end else begin
                     sclk_q <= 1'b1;
                     bit_q  <= bit_q + BIT_W'(1);
                  end
               end
            end
            GAP: begin
               div_q <= div_d;
               if (div_wrap_d) begin
                  sh_q    <= '0;
                  mosi_q  <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               div_q   <= '0;
               bit_q   <= '0;
               ready_q <= 1'b1;
               cs_n_q  <= 1'b1;
               sclk_q  <= 1'b0;
               mosi_q  <= 1'b0;
            end
         endcase
      end
   end

   assign __output = {done_q, ready_q, cs_n_q, sclk_q, mosi_q};

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: one instance at CLK_DIV=4 and one at CLK_DIV=1,
// both observed by a mode-0 receiver model sampling mosi on sclk rising edges.
module tb_spi_master_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data0 = 8'h00;
   logic       valid0 = 1'b0;
   logic [4:0] out0;
   logic [7:0] data1 = 8'h00;
   logic       valid1 = 1'b0;
   logic [4:0] out1;

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;

   // Per-instance observations, indexed by instance (0: CLK_DIV=4, 1: CLK_DIV=1).
   logic [4:0]  prev [2];
   int          fall_e [2];
   int          rise_e [2];
   int          sclk1_e [2];
   int          ready_e [2];
   int          done_e [2];
   int          n_fall [2];
   int          n_frame [2];
   int          n_done [2];
   int          nb [2];
   int          last_nb [2];
   logic [31:0] sh [2];
   logic [31:0] last_frame [2];
   int          viol = 0;

   spi_master_tx #(.CLK_DIV(4), .DATA_W(8)) u_dut (
      ._i_clk(clk), ._i_rst(rst_n), ._i_data(data0), ._i_valid(valid0), .__output(out0)
   );

   spi_master_tx #(.CLK_DIV(1), .DATA_W(8)) u_dut1 (
      ._i_clk(clk), ._i_rst(rst_n), ._i_data(data1), ._i_valid(valid1), .__output(out1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Receiver and protocol monitor, sampling on the falling clock edge.
   initial begin
      for (int i = 0; i < 2; i++) begin
         prev[i] = 5'b01100; fall_e[i] = -1; rise_e[i] = -1; sclk1_e[i] = -1;
         ready_e[i] = -1; done_e[i] = -1; n_fall[i] = 0; n_frame[i] = 0;
         n_done[i] = 0; nb[i] = 0; last_nb[i] = 0; sh[i] = '0; last_frame[i] = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            logic [4:0] o;
            o = (i == 0) ? out0 : out1;
            if (prev[i][2] && !o[2]) begin
               fall_e[i] = cyc; n_fall[i]++; sh[i] = '0; nb[i] = 0; sclk1_e[i] = -1;
            end
            if (o[2] && prev[i][2] && (o[1] != prev[i][1])) viol++;
            if (!prev[i][1] && o[1] && !o[2]) begin
               if (o[0] != prev[i][0]) viol++;
               if (nb[i] == 0) sclk1_e[i] = cyc;
               sh[i] = {sh[i][30:0], o[0]};
               nb[i]++;
            end
            if (!prev[i][2] && o[2]) begin
               rise_e[i] = cyc; last_frame[i] = sh[i]; last_nb[i] = nb[i]; n_frame[i]++;
            end
            if (o[4]) begin
               n_done[i]++; done_e[i] = cyc;
            end
            if (!prev[i][3] && o[3]) ready_e[i] = cyc;
            prev[i] = o;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents one word for a single edge; k is the index of the accepting edge.
   task automatic send(input int sel, input logic [7:0] d, output int k);
      if (sel == 0) begin
         data0 = d; valid0 = 1'b1;
      end else begin
         data1 = d; valid1 = 1'b1;
      end
      @(posedge clk);
      #1;
      k = cyc;
      if (sel == 0) valid0 = 1'b0;
      else valid1 = 1'b0;
   endtask

   task automatic wait_frame(input int sel, input int n0);
      int guard;
      guard = 0;
      while (n_frame[sel] <= n0 && guard < 400) begin
         tick(1);
         guard++;
      end
      chk("frame_timeout", 32'(n_frame[sel] > n0), 32'd1);
   endtask

   initial begin
      int k, k2, nf, nd, nfl, r1;
      logic [7:0] vec [3];
      vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h96;

      tick(3);
      chk("reset_out", 32'(out0), 32'h0C);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("idle_hold", 32'(out0), 32'h0C);
      end

      // Single frame 0xA5
      nf = n_frame[0]; nd = n_done[0];
      send(0, 8'hA5, k);
      chk("a5_after_accept", 32'(out0), 32'h01);
      wait_frame(0, nf);
      tick(8);
      chk("a5_cs_fall", 32'(fall_e[0] - k), 32'd0);
      chk("a5_first_rise", 32'(sclk1_e[0] - k), 32'd4);
      chk("a5_bits", last_frame[0], 32'hA5);
      chk("a5_nbits", 32'(last_nb[0]), 32'd8);
      chk("a5_cs_rise", 32'(rise_e[0] - k), 32'd68);
      chk("a5_done_at", 32'(done_e[0] - k), 32'd68);
      chk("a5_done_cnt", 32'(n_done[0] - nd), 32'd1);
      chk("a5_ready_back", 32'(ready_e[0] - k), 32'd72);

      // Back-to-back with valid held high
      nf = n_frame[0];
      data0 = 8'h3C; valid0 = 1'b1;
      @(posedge clk);
      #1;
      k = cyc;
      data0 = 8'hC3;
      wait_frame(0, nf);
      chk("b2b_first_bits", last_frame[0], 32'h3C);
      r1 = rise_e[0];
      while (cyc < k + 73) tick(1);
      valid0 = 1'b0;
      tick(2);
      chk("b2b_second_accept", 32'(fall_e[0] - k), 32'd73);
      chk("b2b_cs_high_start", 32'(r1 - k), 32'd68);
      wait_frame(0, nf + 1);
      chk("b2b_second_bits", last_frame[0], 32'hC3);
      tick(8);

      // Ignored valid and data changes mid-frame
      nf = n_frame[0]; nd = n_done[0]; nfl = n_fall[0];
      send(0, 8'h81, k);
      data0 = 8'h5E;
      tick(19);
      data0 = 8'hFF; valid0 = 1'b1;
      tick(1);
      valid0 = 1'b0; data0 = 8'h7E;
      wait_frame(0, nf);
      chk("ign_bits", last_frame[0], 32'h81);
      tick(150);
      chk("ign_done_cnt", 32'(n_done[0] - nd), 32'd1);
      chk("ign_no_extra", 32'(n_fall[0] - nfl), 32'd1);

      // Asynchronous reset during bit 3
      nd = n_done[0];
      send(0, 8'h96, k);
      while (cyc < k + 32) tick(1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_async_out", 32'(out0[3:0]), 32'hC);
      tick(3);
      rst_n = 1'b1;
      nfl = n_fall[0];
      tick(100);
      chk("rst_no_done", 32'(n_done[0] - nd), 32'd0);
      chk("rst_no_resume", 32'(n_fall[0] - nfl), 32'd0);
      nf = n_frame[0];
      send(0, 8'h5A, k);
      wait_frame(0, nf);
      chk("post_rst_bits", last_frame[0], 32'h5A);
      chk("post_rst_nbits", 32'(last_nb[0]), 32'd8);
      tick(8);

      // CLK_DIV=1 loopback
      for (int v = 0; v < 3; v++) begin
         nf = n_frame[1];
         send(1, vec[v], k);
         wait_frame(1, nf);
         chk("div1_bits", last_frame[1], 32'(vec[v]));
         chk("div1_cs_low", 32'(rise_e[1] - fall_e[1]), 32'd17);
         tick(4);
      end

      chk("protocol_invariants", 32'(viol), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
